// File: rtl/mem_port_initiator.sv
// rtl/mem_port_initiator.sv - sized byte-address request driver for a 1-cycle-latency W0/R0 SRAM model
// Ports:
//   clock, reset_n     single clock, synchronous active-low reset
//   req_*              valid/ready request channel: write, byte addr, size (1/2/4/8 B), right-aligned wdata
//   resp_*             valid/ready in-order response channel: is_read, err, rdata (right-aligned)
//   W0_*               memory write port: clk, doubleword addr, en, data, byte mask
//   R0_*               memory read port: clk, doubleword addr, en; R0_data returns the cycle after R0_en
module mem_port_initiator #(
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          ADDR_W     = 28,
  parameter int          RESP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_is_read,
  output logic              resp_err,
  output logic [63:0]       resp_rdata,
  output logic              W0_clk,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [63:0]       W0_data,
  output logic [7:0]        W0_mask,
  output logic              R0_clk,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [63:0]       R0_data
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [63:0]   WIN_BYTES = 64'd1 << (ADDR_W + 3);
  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(RESP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(RESP_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  function automatic logic [7:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_bits(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Stage 1: request in flight while the memory performs its 1-cycle read
  logic       s1_valid;
  logic       s1_is_read;
  logic       s1_err;
  logic [1:0] s1_size;
  logic [2:0] s1_off;

  // Response FIFO
  logic          fifo_is_read [RESP_DEPTH];
  logic          fifo_err     [RESP_DEPTH];
  logic [63:0]   fifo_rdata   [RESP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [CW:0]   occ;
  logic          accept;
  logic          pop;
  logic [63:0]   rel;
  logic          misaligned;
  logic          out_of_window;
  logic          req_err;
  logic [2:0]    off;
  logic [ADDR_W-1:0] dw;
  logic [63:0]   push_rdata;

  assign W0_clk = clock;
  assign R0_clk = clock;

  // Stage 1 counts as a reserved slot, so a push can never find the FIFO full.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign req_ready = reset_n && (occ < DEPTH_C);
  assign accept    = req_valid && req_ready;

  assign rel           = req_addr - BASE;
  assign off           = req_addr[2:0];
  assign dw            = rel[ADDR_W+2:3];
  assign misaligned    = |(req_addr[2:0] & align_bits(req_size));
  assign out_of_window = (req_addr < BASE) || (rel >= WIN_BYTES);
  assign req_err       = misaligned || out_of_window;

  always_comb begin
    W0_en   = 1'b0;
    W0_addr = '0;
    W0_data = '0;
    W0_mask = '0;
    R0_en   = 1'b0;
    R0_addr = '0;
    if (accept && !req_err) begin
      if (req_write) begin
        W0_en   = 1'b1;
        W0_addr = dw;
        W0_data = req_wdata << {off, 3'b000};
        W0_mask = size_bytes(req_size) << off;
      end else begin
        R0_en   = 1'b1;
        R0_addr = dw;
      end
    end
  end

  assign push_rdata = (s1_is_read && !s1_err)
                    ? ((R0_data >> {s1_off, 3'b000}) & size_mask(s1_size))
                    : '0;

  assign resp_valid   = (count != '0);
  assign pop          = resp_valid && resp_ready;
  assign resp_is_read = resp_valid && fifo_is_read[rd_ptr];
  assign resp_err     = resp_valid && fifo_err[rd_ptr];
  assign resp_rdata   = resp_valid ? fifo_rdata[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_is_read <= 1'b0;
      s1_err     <= 1'b0;
      s1_size    <= '0;
      s1_off     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_is_read <= !req_write;
        s1_err     <= req_err;
        s1_size    <= req_size;
        s1_off     <= off;
      end
      if (s1_valid) begin
        fifo_is_read[wr_ptr] <= s1_is_read;
        fifo_err[wr_ptr]     <= s1_err;
        fifo_rdata[wr_ptr]   <= push_rdata;
        wr_ptr               <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({s1_valid, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
